// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes and FSM state encoding shared by the sequential ALU
package seq_alu_pkg;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_AND  = 4'b0000;
  localparam alu_op_t ALU_OR   = 4'b0001;
  localparam alu_op_t ALU_ADD  = 4'b0010;
  localparam alu_op_t ALU_SUB  = 4'b0110;
  localparam alu_op_t ALU_SLT  = 4'b0111;
  localparam alu_op_t ALU_SLL  = 4'b1000;
  localparam alu_op_t ALU_SRL  = 4'b1001;
  localparam alu_op_t ALU_SRA  = 4'b1010;
  localparam alu_op_t ALU_NOR  = 4'b1100;
  localparam alu_op_t ALU_MULU = 4'b1101;
  localparam alu_op_t ALU_DIVU = 4'b1110;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative unsigned shift-add multiplier / restoring divider
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic [SHW-1:0] cnt;
  logic [WIDTH-1:0] opd, h0, l0, d0, hi_n, lo_n;
  logic [WIDTH:0] ms, rs, df;
  logic div_q, dv, ok;
  // the first iteration runs on the start edge straight from the inputs
  assign dv = start ? op_is_div : div_q;
  assign h0 = start ? '0 : hi;
  assign l0 = start ? (op_is_div ? a : b) : lo;
  assign d0 = start ? (op_is_div ? b : a) : opd;
  assign ms = {1'b0, h0} + (l0[0] ? {1'b0, d0} : {(WIDTH+1){1'b0}});
  assign rs = {h0, l0[WIDTH-1]};
  assign df = rs - {1'b0, d0};
  assign ok = !df[WIDTH];
  assign hi_n = dv ? (ok ? df[WIDTH-1:0] : rs[WIDTH-1:0]) : ms[WIDTH:1];
  assign lo_n = dv ? {l0[WIDTH-2:0], ok} : {ms[0], l0[WIDTH-1:1]};
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      opd <= '0;
      div_q <= 1'b0;
    end else begin
      done <= busy && cnt == SHW'(WIDTH-1);
      if (start || busy) begin
        hi <= hi_n;
        lo <= lo_n;
        opd <= d0;
        div_q <= dv;
      end
      if (start) begin
        busy <= 1'b1;
        cnt <= SHW'(1);
      end else if (busy) begin
        cnt <= cnt + SHW'(1);
        if (cnt == SHW'(WIDTH-1)) busy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result, flags and iterative MULU/DIVU
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] first_operand,
  input  logic [WIDTH-1:0] second_operand,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);
  logic [1:0] state;
  logic [WIDTH-1:0] a, b, sum, diff, alu_res, alu_hi, md_lo, md_hi;
  logic [SHW-1:0] sh;
  logic is_add, is_sub, is_mul, is_div, alu_ovf, accept, start, md_busy, md_done;
  assign a = first_operand;
  assign b = second_operand;
  assign sh = b[SHW-1:0];
  assign sum = a + b;
  assign diff = a - b;
  assign is_sub = alu_control == ALU_SUB;
  assign is_mul = alu_control == ALU_MULU;
  assign is_div = alu_control == ALU_DIVU;
  always_comb begin
    alu_res = sum;
    is_add = 1'b0;
    case (alu_control)
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_NOR:  alu_res = ~(a | b);
      ALU_SUB:  alu_res = diff;
      ALU_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      ALU_SLL:  alu_res = a << sh;
      ALU_SRL:  alu_res = a >> sh;
      ALU_SRA:  alu_res = $signed(a) >>> sh;
      ALU_MULU: alu_res = '0;
      ALU_DIVU: alu_res = '1;
      default:  is_add = 1'b1;
    endcase
  end
  assign alu_ovf = is_add ? (a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]) :
                   is_sub ? (a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
  // only a divide-by-zero reaches the single-cycle path with a nonzero high word
  assign alu_hi = is_div ? a : '0;
  assign in_ready = state == S_IDLE && !md_busy;
  assign out_valid = state == S_DONE;
  assign accept = in_valid && in_ready;
  assign start = accept && (is_mul || (is_div && b != '0));
  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk(clk), .reset(reset), .start(start), .op_is_div(is_div), .a(a), .b(b),
    .busy(md_busy), .done(md_done), .lo(md_lo), .hi(md_hi)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      result <= '0;
      result_hi <= '0;
      zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state <= is_mul ? S_MUL : start ? S_DIV : S_DONE;
          if (!start) begin
            result <= alu_res;
            result_hi <= alu_hi;
            zero <= alu_res == '0;
            overflow <= alu_ovf;
          end
        end
        S_MUL, S_DIV: if (md_done) begin
          state <= S_DONE;
          result <= md_lo;
          result_hi <= md_hi;
          zero <= md_lo == '0;
          overflow <= 1'b0;
        end
        default: if (out_ready) state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Adds a registered result, signed overflow, SLT, shifts, and iterative unsigned multiply/divide with hi/lo results.
- Sits between the register-read stage and writeback in the multi-cycle core.
- Valid/ready on both sides lets the control FSM stall while MULU/DIVU iterate.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits, derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- first_operand  input  WIDTH  operand A
- second_operand  input  WIDTH  operand B; low SHW bits are the shift amount
- alu_control  input  4  opcode
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  main result / product low / quotient
- result_hi  output  WIDTH  product high / remainder; 0 for other ops
- zero  output  1  result == 0
- overflow  output  1  signed overflow, ADD/SUB only, else 0

Behaviour:
- Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 1100 NOR; 0111 SLT (signed, result 1 or 0); 1000 SLL; 1001 SRL; 1010 SRA; 1101 MULU; 1110 DIVU. Any other code executes ADD.
- FSM states: IDLE, MUL, DIV, DONE. in_ready = (state == IDLE).
- Accept: in_valid && in_ready at a rising edge. Operands and opcode are latched at that edge; later input changes are ignored.
- Single-cycle ops: IDLE -> DONE at the accept edge. out_valid is high in the next cycle (latency 1).
- MULU: IDLE -> MUL. Unsigned shift-add, one bit per cycle, WIDTH iterations, then -> DONE. out_valid asserts WIDTH+1 cycles after accept. {result_hi, result} = full 2*WIDTH-bit product.
- DIVU: IDLE -> DIV. Unsigned restoring division, WIDTH iterations, then -> DONE. Latency WIDTH+1. result = quotient; result_hi = remainder.
- DIVU by zero: IDLE -> DONE directly (latency 1). result = all ones; result_hi = dividend.
- DONE: out_valid = 1. result, result_hi, zero and overflow are held stable until out_valid && out_ready at an edge, then -> IDLE.
- No new request is accepted in DONE. Peak throughput is one single-cycle op per 2 cycles.
- zero and overflow are registered together with result.
- overflow: ADD sets it when the operand signs match and the result sign differs. SUB sets it when the operand signs differ and the result sign differs from A.
- All arithmetic is modulo 2^WIDTH except MULU (2*WIDTH-bit product).
- Shift amount = second_operand[SHW-1:0]; upper bits are ignored.
- reset, including mid-MUL/DIV: state = IDLE; in-flight operation discarded; out_valid = 0; result = 0; result_hi = 0; zero = 0; overflow = 0. in_ready = 1 in the cycle after reset deasserts.
- in_valid while busy is ignored; the requester must hold it until in_ready.

Decomposition:
- Shared package seq_alu_pkg holds:
  - the 4-bit opcode localparams (ALU_AND ... ALU_DIVU);
  - the FSM state encoding.
  - The control unit reuses the opcodes.
- One sub-module, seq_alu_muldiv: the iterative unsigned multiply/divide engine.
  - Ports: start, op_is_div, a, b, busy, done, lo, hi.
  - Contains the WIDTH-cycle iteration counter, partial product/remainder and shift registers.
- Top level handles single-cycle ops, flags, FSM and handshakes.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0, result_hi=0.
- SUB 5 - 5, then SLT 0xFFFFFFFF vs 0x00000001 -> first result=0, zero=1, overflow=0; second result=1.
- SRA 0x80000000 by second_operand=0x00000024 (amount 4) -> 0xF8000000. SRL same inputs -> 0x08000000.
- MULU 0xFFFFFFFF * 0xFFFFFFFF -> in_ready=0 for 32 iteration cycles. out_valid asserts exactly 33 cycles after accept; result_hi=0xFFFFFFFE, result=0x00000001.
- DIVU 100 / 7 -> latency 33, result=14, result_hi=2. DIVU 0x1234 / 0 -> latency 1, result=0xFFFFFFFF, result_hi=0x00001234.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after an AND result -> out_valid, result and in_ready=0 stable throughout.
  - Assert reset 10 cycles into a MULU -> next cycle out_valid=0, result=0, state IDLE, in_ready=1 once reset drops.
